// File: rtl/axi_lite_host_master_if.sv
// AXI4-Lite bus bundle between the host-side initiator and the coprocessor slave port.
// The master modport belongs to the initiator, the slave modport to the responder.
interface axi_lite_host_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned StrbW = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [StrbW-1:0]  WSTRB;
  logic              WVALID;
  logic              WREADY;

  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;

  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_lite_host_master.sv
// AXI4-Lite initiator: turns single-word valid/ready commands into one outstanding
// AXI4-Lite write or read at a time, reporting completion as a one-cycle response pulse.
module axi_lite_host_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,

  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_W-1:0]     CMD_ADDR,
  input  logic [DATA_W-1:0]     CMD_WDATA,
  input  logic [DATA_W/8-1:0]   CMD_WSTRB,

  output logic                  RSP_VALID,
  output logic [DATA_W-1:0]     RSP_RDATA,
  output logic [1:0]            RSP_RESP,

  axi_lite_host_master_if.master axi
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata
  } state_e;

  state_e              state_q;
  logic                live_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [StrbW-1:0]    wstrb_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  // A write channel counts as done once its VALID has already dropped or is accepted now.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || axi.AWREADY;
  assign w_done  = !wvalid_q  || axi.WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      live_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      live_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (CMD_VALID && live_q) begin
            addr_q  <= CMD_ADDR;
            wdata_q <= CMD_WDATA;
            wstrb_q <= CMD_WSTRB;
            if (CMD_WRITE) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrite;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRead;
            end
          end
        end
        StWrite: begin
          if (axi.AWREADY) begin
            awvalid_q <= 1'b0;
          end
          if (axi.WREADY) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= StWresp;
          end
        end
        StWresp: begin
          if (axi.BVALID) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= axi.BRESP;
            state_q     <= StIdle;
          end
        end
        StRead: begin
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (axi.RVALID) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= axi.RDATA;
            rsp_resp_q  <= axi.RRESP;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // live_q keeps the command port closed while reset is asserted.
  assign CMD_READY   = live_q && (state_q == StIdle);
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_RESP    = rsp_resp_q;

  assign axi.AWADDR  = addr_q;
  assign axi.AWPROT  = PROT;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARPROT  = PROT;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

  // A VALID is never withdrawn before its handshake and its payload holds still.
  a_aw_hold: assert property (@(posedge ACLK) disable iff (!ARESETN)
    awvalid_q && !axi.AWREADY |=> awvalid_q && $stable(addr_q));
  a_w_hold: assert property (@(posedge ACLK) disable iff (!ARESETN)
    wvalid_q && !axi.WREADY |=> wvalid_q && $stable(wdata_q) && $stable(wstrb_q));
  a_ar_hold: assert property (@(posedge ACLK) disable iff (!ARESETN)
    arvalid_q && !axi.ARREADY |=> arvalid_q && $stable(addr_q));

endmodule

// File: tb/tb_axi_lite_host_master.sv
// Bench for axi_lite_host_master: stalling AXI4-Lite slave with a byte-strobed memory,
// directed latency/ordering steps, then a randomly stalled 256-word burst with readback.
module tb_axi_lite_host_master;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;

  axi_lite_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_host_master #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
    .CMD_WSTRB (CMD_WSTRB),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_RESP  (RSP_RESP),
    .axi       (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_pass = 0;
  int ncyc = 0;

  // Slave configuration and state
  bit          rand_mode = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  bit          have_aw, have_w, have_ar, b_fire, r_fire;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] smem [logic [31:0]];
  logic [67:0] got_wr [$];

  // Monitor results
  int          aw_first = -1, aw_hi = 0, w_hi = 0, rsp_cnt = 0, rsp_bad = 0;
  bit          aw_unstable = 0, bready_early = 0;
  logic [31:0] aw_addr_prev;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit coin();
    return $urandom_range(0, 2) == 0;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  initial forever begin
    @(posedge ACLK);
    ncyc++;
  end

  initial forever begin
    @(posedge ACLK);
    #1;
    if (bus.AWVALID === 1'b1) begin
      if (aw_first < 0) aw_first = ncyc;
      aw_hi++;
      if (aw_hi > 1 && bus.AWADDR !== aw_addr_prev) aw_unstable = 1;
      aw_addr_prev = bus.AWADDR;
    end
    if (bus.WVALID === 1'b1) w_hi++;
    if (bus.BREADY === 1'b1 && (bus.AWVALID === 1'b1 || bus.WVALID === 1'b1)) bready_early = 1;
    if (RSP_VALID === 1'b1) begin
      rsp_cnt++;
      if (RSP_RESP !== 2'b00) rsp_bad++;
    end
  end

  // Slave: decides everything at the falling edge; the DUT samples at the next rising edge.
  initial begin
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    forever begin
      @(negedge ACLK);
      if (ARESETN !== 1'b1) begin
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RVALID = 0;
        have_aw = 0; have_w = 0; have_ar = 0; b_fire = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (b_fire) begin bus.BVALID = 0; b_fire = 0; end
        if (r_fire) begin bus.RVALID = 0; r_fire = 0; end
        if (have_aw && have_w && !bus.BVALID) begin
          if (rand_mode ? coin() : (b_cnt >= b_dly)) begin
            bus.BVALID = 1; bus.BRESP = b_resp; b_cnt = 0;
          end else b_cnt++;
        end
        if (bus.BVALID && bus.BREADY === 1'b1) begin
          logic [31:0] cur;
          cur = rd_word(s_awaddr);
          for (int b = 0; b < 4; b++) if (s_wstrb[b]) cur[8*b +: 8] = s_wdata[8*b +: 8];
          smem[s_awaddr] = cur;
          got_wr.push_back({s_awaddr, s_wdata, s_wstrb});
          b_fire = 1; have_aw = 0; have_w = 0;
        end
        if (have_ar && !bus.RVALID) begin
          if (rand_mode ? coin() : (r_cnt >= r_dly)) begin
            bus.RVALID = 1; bus.RDATA = rd_word(s_araddr); bus.RRESP = r_resp; r_cnt = 0;
          end else r_cnt++;
        end
        if (bus.RVALID && bus.RREADY === 1'b1) begin r_fire = 1; have_ar = 0; end
        bus.AWREADY = 0;
        if (bus.AWVALID === 1'b1 && !have_aw) begin
          if (rand_mode ? coin() : (aw_cnt >= aw_dly)) begin
            bus.AWREADY = 1; have_aw = 1; s_awaddr = bus.AWADDR; aw_cnt = 0;
          end else aw_cnt++;
        end
        bus.WREADY = 0;
        if (bus.WVALID === 1'b1 && !have_w) begin
          if (rand_mode ? coin() : (w_cnt >= w_dly)) begin
            bus.WREADY = 1; have_w = 1; s_wdata = bus.WDATA; s_wstrb = bus.WSTRB; w_cnt = 0;
          end else w_cnt++;
        end
        bus.ARREADY = 0;
        if (bus.ARVALID === 1'b1 && !have_ar) begin
          if (rand_mode ? coin() : (ar_cnt >= ar_dly)) begin
            bus.ARREADY = 1; have_ar = 1; s_araddr = bus.ARADDR; ar_cnt = 0;
          end else ar_cnt++;
        end
      end
    end
  end

  task automatic clr_mon();
    aw_first = -1; aw_hi = 0; w_hi = 0; aw_unstable = 0; bready_early = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
    int n = 0;
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    while (CMD_READY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    acc = ncyc;
    if (n >= 100) check("cmd_accept_timeout", 0, 1);
    @(negedge ACLK);
    CMD_VALID = 0;
  endtask

  task automatic wait_rsp(input string tag, output int cyc, output logic [31:0] rd,
                          output logic [1:0] rs);
    int n = 0;
    while (RSP_VALID !== 1'b1 && n < 300) begin @(negedge ACLK); n++; end
    if (n >= 300) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      cyc = -1; rd = 'x; rs = 'x;
    end else begin
      cyc = ncyc; rd = RSP_RDATA; rs = RSP_RESP;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, acc2, c, base, bad0;
    logic [31:0] rd, d;
    logic [1:0]  rs;
    logic [67:0] exp_q [$];
    logic [31:0] exp_mem [256];

    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0;
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_awvalid", bus.AWVALID, 0);
    check("rst_wvalid", bus.WVALID, 0);
    check("rst_arvalid", bus.ARVALID, 0);
    check("rst_bready", bus.BREADY, 0);
    check("rst_rready", bus.RREADY, 0);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_data", {RSP_RDATA, RSP_RESP}, 0);
    check("rst_addr_data", {bus.AWADDR, bus.WDATA, bus.WSTRB}, 0);
    @(posedge ACLK);
    #2 ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check("rst_cmd_ready", CMD_READY, 1);

    // Zero-wait write
    got_wr.delete(); clr_mon();
    issue(1, 32'h004, 32'hDEADBEEF, 4'hF, acc);
    wait_rsp("wr0", c, rd, rs);
    check("wr0_aw_first", aw_first, acc + 1);
    check("wr0_aw_cycles", aw_hi, 1);
    check("wr0_w_cycles", w_hi, 1);
    check("wr0_rsp_cycle", c, acc + 3);
    check("wr0_resp", rs, 2'b00);
    check("wr0_rdata", rd, 0);
    check("wr0_prot", bus.AWPROT, 3'b000);
    check("wr0_count", got_wr.size(), 1);
    check("wr0_word", got_wr[0], {32'h004, 32'hDEADBEEF, 4'hF});
    @(negedge ACLK);

    // AWREADY late by three cycles, WREADY immediate
    aw_dly = 3; clr_mon();
    issue(1, 32'h008, 32'hCAFEF00D, 4'hF, acc);
    wait_rsp("wr1", c, rd, rs);
    check("wr1_w_cycles", w_hi, 1);
    check("wr1_aw_cycles", aw_hi, 4);
    check("wr1_awaddr_stable", aw_unstable, 0);
    check("wr1_bready_order", bready_early, 0);
    check("wr1_rsp_cycle", c, acc + 6);
    check("wr1_resp", rs, 2'b00);
    aw_dly = 0;
    @(negedge ACLK);

    // Read with two R wait cycles
    smem[32'h400] = 32'h0000_0007;
    r_dly = 2; base = rsp_cnt;
    issue(0, 32'h400, 0, 0, acc);
    wait_rsp("rd0", c, rd, rs);
    check("rd0_rdata", rd, 32'h7);
    check("rd0_resp", rs, 2'b00);
    check("rd0_rsp_cycle", c, acc + 5);
    repeat (5) @(negedge ACLK);
    check("rd0_single_pulse", rsp_cnt - base, 1);
    r_dly = 0;

    // SLVERR read, then a command accepted in the response cycle
    r_resp = 2'b10;
    issue(0, 32'h004, 0, 0, acc);
    wait_rsp("rd1", c, rd, rs);
    check("rd1_resp", rs, 2'b10);
    check("rd1_rdata", rd, 32'hDEADBEEF);
    check("b2b_cmd_ready", CMD_READY, 1);
    r_resp = 2'b00;
    issue(1, 32'h010, 32'h12345678, 4'h3, acc2);
    check("b2b_accept_cycle", acc2, c);
    wait_rsp("wr2", c, rd, rs);
    check("wr2_resp", rs, 2'b00);
    @(negedge ACLK);
    issue(0, 32'h010, 0, 0, acc);
    wait_rsp("rd2", c, rd, rs);
    check("rd2_strobed", rd, 32'h0000_5678);
    @(negedge ACLK);

    // Reset while ARVALID waits for ARREADY
    ar_dly = 1000;
    issue(0, 32'h400, 0, 0, acc);
    @(negedge ACLK);
    check("arst_arvalid_before", bus.ARVALID, 1);
    base = rsp_cnt;
    ARESETN = 1'b0;
    #1;
    check("arst_arvalid_async", bus.ARVALID, 0);
    repeat (2) @(negedge ACLK);
    @(posedge ACLK);
    #2 ARESETN = 1'b1;
    ar_dly = 0;
    repeat (2) @(negedge ACLK);
    check("arst_cmd_ready", CMD_READY, 1);
    repeat (10) @(negedge ACLK);
    check("arst_no_rsp", rsp_cnt - base, 0);

    // 256-word image window with random stalls on every channel
    rand_mode = 1; got_wr.delete(); base = rsp_cnt; bad0 = rsp_bad;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      exp_mem[i] = d;
      exp_q.push_back({32'(i * 4), d, 4'hF});
      issue(1, 32'(i * 4), d, 4'hF, acc);
      wait_rsp("burst", c, rd, rs);
    end
    @(negedge ACLK);
    check("burst_rsp_count", rsp_cnt - base, 256);
    check("burst_rsp_okay", rsp_bad - bad0, 0);
    check("burst_word_count", got_wr.size(), 256);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("burst_word_%0d", i), got_wr[i], exp_q[i]);
    end
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = $urandom_range(0, 255);
      issue(0, 32'(idx * 4), 0, 0, acc);
      wait_rsp("readback", c, rd, rs);
      check($sformatf("readback_%0d", idx), {rd, rs}, {exp_mem[idx], 2'b00});
      @(negedge ACLK);
    end
    rand_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
